// File: rtl/bp_be_fp_aux_pipe_ctl.sv
// Issue/writeback control around the auxiliary FP pipe: registers operands
// into the free-running aux datapath, tracks ops with a tag pipe, and catches
// results in a credit-protected FIFO. Also holds the sticky fflags for fcsr.

package bp_be_fp_aux_pipe_ctl_pkg;
   typedef enum logic [3:0] {
      e_op_fmin, e_op_fmax, e_op_feq, e_op_flt, e_op_fle, e_op_fsgnj,
      e_op_fsgnjn, e_op_fsgnjx, e_op_i2f, e_op_f2f, e_op_imvf
   } bp_be_fp_fu_op_e;

   typedef enum logic {e_pr_single = 1'b0, e_pr_double = 1'b1} bp_be_fp_pr_e;

   typedef enum logic [2:0] {
      e_rne = 3'b000, e_rtz = 3'b001, e_rdn = 3'b010, e_rup = 3'b011,
      e_rmm = 3'b100, e_dyn = 3'b111
   } rv64_frm_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } rv64_fflags_s;
endpackage

module bp_be_fp_aux_pipe_ctl
   import bp_be_fp_aux_pipe_ctl_pkg::*;
#(
   parameter int latency_p     = 2,
   parameter int dword_width_p = 64,
   parameter int els_p         = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [dword_width_p-1:0] a_i,
   input  logic [dword_width_p-1:0] b_i,
   input  bp_be_fp_fu_op_e          op_i,
   input  bp_be_fp_pr_e             ipr_i,
   input  bp_be_fp_pr_e             opr_i,
   input  rv64_frm_e                rm_i,
   input  logic [4:0]               rd_addr_i,
   input  logic                     flush_i,
   output logic [dword_width_p-1:0] aux_a_o,
   output logic [dword_width_p-1:0] aux_b_o,
   output bp_be_fp_fu_op_e          aux_op_o,
   output bp_be_fp_pr_e             aux_ipr_o,
   output bp_be_fp_pr_e             aux_opr_o,
   output rv64_frm_e                aux_rm_o,
   input  logic [dword_width_p-1:0] aux_data_i,
   input  rv64_fflags_s             aux_eflags_i,
   output logic                     v_o,
   input  logic                     yumi_i,
   output logic [dword_width_p-1:0] data_o,
   output logic [4:0]               rd_addr_o,
   output logic [4:0]               eflags_o,
   input  logic                     fflags_w_v_i,
   input  logic [4:0]               fflags_i,
   output logic [4:0]               fflags_o
);

   localparam int occ_w = $clog2(els_p + 1);
   localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

   logic [occ_w-1:0]         occ;
   logic                     acc, deq, push, full, empty;
   logic [latency_p-1:0]     vld_pipe;
   logic [4:0]               rd_pipe [latency_p];
   logic [dword_width_p-1:0] data_mem [els_p];
   logic [4:0]               flags_mem [els_p];
   logic [4:0]               rd_mem [els_p];
   logic [ptr_w-1:0]         wr_ptr, rd_ptr;
   logic [occ_w-1:0]         cnt;
   logic [4:0]               deq_flags;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
   endfunction

   // Credits cover both the tag pipe and the FIFO, so a push can never overflow.
   assign ready_o   = ~reset_i & ~flush_i & (occ < occ_w'(els_p));
   assign acc       = v_i & ready_o;
   assign deq       = v_o & yumi_i & ~flush_i;
   assign push      = vld_pipe[latency_p-1];
   assign full      = (cnt == occ_w'(els_p));
   assign empty     = (cnt == '0);
   assign v_o       = ~empty;
   assign data_o    = empty ? '0 : data_mem[rd_ptr];
   assign rd_addr_o = empty ? '0 : rd_mem[rd_ptr];
   assign eflags_o  = empty ? '0 : flags_mem[rd_ptr];
   assign deq_flags = deq ? eflags_o : '0;

   // In-flight plus buffered op count; drives the credit check.
   always_ff @(posedge clk_i) begin
      if (reset_i | flush_i) occ <= '0;
      else                   occ <= occ + occ_w'(acc) - occ_w'(deq);
   end

   // Issue register: holds the last accepted op so the datapath input is stable.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         aux_a_o   <= '0;
         aux_b_o   <= '0;
         aux_op_o  <= e_op_fmin;
         aux_ipr_o <= e_pr_single;
         aux_opr_o <= e_pr_single;
         aux_rm_o  <= e_rne;
      end else if (acc) begin
         aux_a_o   <= a_i;
         aux_b_o   <= b_i;
         aux_op_o  <= op_i;
         aux_ipr_o <= ipr_i;
         aux_opr_o <= opr_i;
         aux_rm_o  <= rm_i;
      end
   end

   // Tag valids shadow the datapath; last stage lines up with aux_data_i.
   always_ff @(posedge clk_i) begin
      if (reset_i | flush_i) vld_pipe <= '0;
      else begin
         vld_pipe[0] <= acc;
         for (int i = 1; i < latency_p; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // Destination tags need no reset; they are qualified by vld_pipe.
   always_ff @(posedge clk_i) begin
      rd_pipe[0] <= rd_addr_i;
      for (int i = 1; i < latency_p; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   // FIFO pointers and fill count; flush drops everything buffered.
   always_ff @(posedge clk_i) begin
      if (reset_i | flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (deq)  rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + occ_w'(push) - occ_w'(deq);
      end
   end

   // FIFO storage.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem[wr_ptr]  <= aux_data_i;
         flags_mem[wr_ptr] <= aux_eflags_i;
         rd_mem[wr_ptr]    <= rd_pipe[latency_p-1];
      end
   end

   // Sticky flags: CSR write replaces, dequeued result flags OR in the same cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) fflags_o <= '0;
      else         fflags_o <= (fflags_w_v_i ? fflags_i : fflags_o) | deq_flags;
   end

   overflow_a: assert property (@(posedge clk_i) disable iff (reset_i) push |-> !full);

endmodule

// File: tb/tb_bp_be_fp_aux_pipe_ctl.sv
// Randomized scoreboard bench for bp_be_fp_aux_pipe_ctl with a stand-in
// aux datapath model.
module tb_bp_be_fp_aux_pipe_ctl;
   import bp_be_fp_aux_pipe_ctl_pkg::*;

   localparam int L = 2;
   localparam int E = 3;

   logic clk = 0;
   logic reset_i, v_i, ready_o, flush_i, v_o, yumi_i, fflags_w_v_i;
   logic [63:0] a_i, b_i, aux_a_o, aux_b_o, aux_data_i, data_o;
   bp_be_fp_fu_op_e op_i, aux_op_o;
   bp_be_fp_pr_e ipr_i, opr_i, aux_ipr_o, aux_opr_o;
   rv64_frm_e rm_i, aux_rm_o;
   rv64_fflags_s aux_eflags_i;
   logic [4:0] rd_addr_i, rd_addr_o, eflags_o, fflags_i, fflags_o;

   bp_be_fp_aux_pipe_ctl #(.latency_p(L), .dword_width_p(64), .els_p(E)) dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .op_i(op_i), .ipr_i(ipr_i), .opr_i(opr_i),
      .rm_i(rm_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
      .aux_a_o(aux_a_o), .aux_b_o(aux_b_o), .aux_op_o(aux_op_o),
      .aux_ipr_o(aux_ipr_o), .aux_opr_o(aux_opr_o), .aux_rm_o(aux_rm_o),
      .aux_data_i(aux_data_i), .aux_eflags_i(aux_eflags_i),
      .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o), .rd_addr_o(rd_addr_o),
      .eflags_o(eflags_o), .fflags_w_v_i(fflags_w_v_i), .fflags_i(fflags_i),
      .fflags_o(fflags_o));

   always #5 clk = ~clk;

   // Stand-in aux datapath behaviour.
   function automatic logic [63:0] aux_fn(input logic [63:0] a, b, input bp_be_fp_fu_op_e op,
                                          input bp_be_fp_pr_e ip, opr, input rv64_frm_e rm);
      case (op)
         e_op_fmin: return ($bitstoreal(a) < $bitstoreal(b)) ? a : b;
         e_op_fmax: return ($bitstoreal(a) > $bitstoreal(b)) ? a : b;
         default:   return a ^ {b[31:0], b[63:32]} ^ 64'({op, ip, opr, rm});
      endcase
   endfunction

   function automatic logic [4:0] flags_fn(input logic [63:0] a, b, input bp_be_fp_pr_e ip, opr,
                                           input rv64_frm_e rm);
      return a[4:0] ^ b[9:5] ^ {rm, ip, opr};
   endfunction

   // One retiming stage (latency L = 2) after the combinational function.
   always @(posedge clk) begin
      aux_data_i   <= aux_fn(aux_a_o, aux_b_o, aux_op_o, aux_ipr_o, aux_opr_o, aux_rm_o);
      aux_eflags_i <= rv64_fflags_s'(flags_fn(aux_a_o, aux_b_o, aux_ipr_o, aux_opr_o, aux_rm_o));
   end

   typedef struct {
      logic [63:0] d;
      logic [4:0]  f;
      logic [4:0]  rd;
      int          t;
   } exp_t;

   exp_t sb[$];
   int cyc = 0;
   int n_cmp = 0, n_err = 0, n_acc = 0;
   logic [4:0] fm = '0;
   logic yq = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compares outputs against the queue model mid-cycle.
   always @(negedge clk) begin : mon
      logic ev, er, dq;
      logic [4:0] nf;
      ev = (sb.size() > 0) && (sb[0].t + L + 1 <= cyc);
      er = !reset_i && !flush_i && (sb.size() < E);
      chk("ready_o", ready_o, er);
      chk("v_o", v_o, ev);
      if (ev) begin
         chk("data_o", data_o, sb[0].d);
         chk("rd_addr_o", rd_addr_o, sb[0].rd);
         chk("eflags_o", eflags_o, sb[0].f);
      end else begin
         chk("data_o_idle", data_o, 0);
         chk("eflags_o_idle", eflags_o, 0);
      end
      chk("fflags_o", fflags_o, fm);
      dq = ev && yumi_i && !flush_i && !reset_i;
      nf = (fflags_w_v_i ? fflags_i : fm) | (dq ? sb[0].f : 5'h0);
      if (reset_i) begin
         fm = '0;
         sb.delete();
      end else begin
         fm = nf;
         if (flush_i) sb.delete();
         else if (dq) void'(sb.pop_front());
      end
   end

   // Advance one cycle; record the expected response of any accept.
   task automatic tick();
      exp_t e;
      yumi_i = yq & v_o;
      @(negedge clk);
      #1;
      if (v_i && ready_o) begin
         e.d  = aux_fn(a_i, b_i, op_i, ipr_i, opr_i, rm_i);
         e.f  = flags_fn(a_i, b_i, ipr_i, opr_i, rm_i);
         e.rd = rd_addr_i;
         e.t  = cyc;
         sb.push_back(e);
         n_acc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [63:0] a, b, input bp_be_fp_fu_op_e op, input logic [4:0] rd);
      v_i = 1; a_i = a; b_i = b; op_i = op; rd_addr_i = rd;
      ipr_i = e_pr_single; opr_i = e_pr_single; rm_i = e_rne;
   endtask

   task automatic rand_op();
      a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
      op_i = bp_be_fp_fu_op_e'($urandom_range(0, 10));
      ipr_i = bp_be_fp_pr_e'($urandom_range(0, 1));
      opr_i = bp_be_fp_pr_e'($urandom_range(0, 1));
      rm_i = rv64_frm_e'($urandom_range(0, 4));
      rd_addr_i = 5'($urandom);
   endtask

   initial begin : stim
      int n0, k;
      reset_i = 1; v_i = 0; flush_i = 0; fflags_w_v_i = 0; fflags_i = 0; yumi_i = 0;
      issue(0, 0, e_op_fmin, 0); v_i = 0;
      @(posedge clk); #1;
      repeat (3) tick();
      reset_i = 0;
      repeat (2) tick();

      // single fmin op, latency check
      issue(64'h3FF0000000000000, 64'h4000000000000000, e_op_fmin, 7);
      tick();
      v_i = 0; yq = 1;
      for (k = 0; k < 10 && !v_o; k++) tick();
      chk("fmin_latency", k, L);
      chk("fmin_data", data_o, 64'h3FF0000000000000);
      chk("fmin_rd", rd_addr_o, 7);
      chk("fmin_eflags", eflags_o, 0);
      repeat (3) tick();

      // backpressure: credit limit then one yumi pulse
      yq = 0; n0 = n_acc;
      for (int i = 0; i < 6; i++) begin issue(64'(i), 64'h100, e_op_fsgnj, 5'(8 + i)); tick(); end
      chk("bp_accepts", n_acc - n0, E);
      yq = 1; tick(); yq = 0; n0 = n_acc;
      for (int i = 0; i < 4; i++) begin issue(64'(i), 64'h200, e_op_fsgnjx, 5'(16 + i)); tick(); end
      chk("bp_one_more", n_acc - n0, 1);
      v_i = 0; yq = 1;
      repeat (10) tick();

      // flush: one buffered, two in flight, v_i high in the flush cycle
      yq = 0;
      issue(64'h55, 64'h66, e_op_feq, 20); tick();
      v_i = 0; tick(); tick();
      issue(64'h77, 64'h88, e_op_flt, 21); tick();
      issue(64'h99, 64'hAA, e_op_fle, 22); tick();
      issue(64'hBB, 64'hCC, e_op_i2f, 23); flush_i = 1; tick();
      flush_i = 0; v_i = 0; yq = 1;
      chk("flush_v_o", v_o, 0);
      repeat (L + 2) tick();

      // fflags accumulation and CSR write with simultaneous dequeue
      fflags_w_v_i = 1; fflags_i = 0; tick(); fflags_w_v_i = 0;
      issue(64'h10, 0, e_op_fsgnj, 1); tick();
      issue(64'h01, 0, e_op_fsgnj, 2); tick();
      v_i = 0; yq = 1;
      repeat (6) tick();
      chk("fflags_acc", fflags_o, 5'h11);
      yq = 0;
      issue(64'h04, 0, e_op_fsgnj, 3); tick();
      v_i = 0;
      for (k = 0; k < 10 && !v_o; k++) tick();
      chk("wait_v_o", v_o, 1);
      yq = 1; fflags_w_v_i = 1; fflags_i = 0; tick();
      fflags_w_v_i = 0; yq = 0;
      chk("fflags_wr_deq", fflags_o, 5'h04);

      // random streaming
      n0 = n_acc;
      for (int i = 0; i < 3000 && (n_acc - n0) < 100; i++) begin
         rand_op();
         v_i = ($urandom_range(0, 9) < 7);
         yq = $urandom_range(0, 1);
         fflags_w_v_i = ($urandom_range(0, 19) == 0);
         fflags_i = 5'($urandom);
         tick();
      end
      chk("stream_count", n_acc - n0, 100);
      v_i = 0; fflags_w_v_i = 0; yq = 1;
      repeat (10) tick();

      // reset mid-stream with two buffered entries
      yq = 0;
      fflags_w_v_i = 1; fflags_i = 5'h1F; tick(); fflags_w_v_i = 0;
      rand_op(); v_i = 1; tick();
      rand_op(); tick();
      v_i = 0; repeat (4) tick();
      reset_i = 1; tick();
      reset_i = 0; #1;
      chk("rst_v_o", v_o, 0);
      chk("rst_fflags", fflags_o, 0);
      chk("rst_ready", ready_o, 1);
      yq = 1;
      for (int i = 0; i < 8; i++) begin rand_op(); v_i = (i < 4); tick(); end
      v_i = 0; repeat (6) tick();
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
